op_encoder_tx: RTL and testbench
================================

# op_encoder_tx

Host-bound serializer for the monitor-link interface: it sends opcodes from our side back to the host. It takes three request sources: power-on reply, keyboard event and audio sample request. It arbitrates between them, builds a 16-bit opcode (plus a 32-bit payload for keyboard events) and shifts it out MSB-first on a single idle-high serial line. It is the transmit-side counterpart of the opcode decoder on the receive path.

## Interface
Parameters:
- CLKS_PER_BIT, default 4: clk cycles per serial bit; legal range 2..255.
- GUARD_BITS, default 2: idle-high bit times after each frame before the next start bit; legal range 1..15.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- power_on_reply  in  1  one-cycle pulse; queue a power-on reply.
- audio_req  in  1  one-cycle pulse; queue an audio sample request.
- kbd_valid  in  1  keyboard event offered.
- kbd_data  in  32  keyboard payload; sampled on handshake.
- kbd_ready  out  1  combinational: (state==IDLE) && !pwr_pend.
- tx  out  1  serial line, registered, idle 1.
- busy  out  1  registered, 1 in any state other than IDLE.
- frame_done  out  1  registered one-cycle pulse at GUARD→IDLE.

## Operation
- Reset values:
  - tx=1, busy=0, frame_done=0.
  - State IDLE; pwr_pend=0, aud_pend=0; bit timer and bit counter 0.
- Pending flags:
  - A power_on_reply pulse sets pwr_pend; an audio_req pulse sets aud_pend.
  - Further pulses while a flag is set coalesce; there is no counting.
  - A flag clears on the edge its frame is launched.
  - A pulse arriving in the same cycle as the launch of its own type re-sets the flag. Set wins over clear.
- Arbitration in IDLE, evaluated each cycle, highest priority first:
  - pwr_pend: op = OP_PWR_REPLY (16'hC5E0), no payload.
  - kbd_valid && kbd_ready: op = OP_KBD_EVENT (16'hD000), 32-bit payload = kbd_data latched on this edge.
  - aud_pend: op = OP_AUDIO_REQ (16'h0700), no payload.
- States:
  - IDLE: tx=1. On a grant, load the 48-bit shift register {op, payload or 32'h0} and the has_data flag, then go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to OP.
  - OP: 16 bits, shift-register MSB first, each bit held CLKS_PER_BIT cycles. Afterwards go to DATA if has_data, else GUARD.
  - DATA: 32 bits, MSB first, then GUARD.
  - GUARD: tx=1 for GUARD_BITS×CLKS_PER_BIT cycles, then IDLE with frame_done=1 on that edge.
- Bit timer:
  - Counts CLKS_PER_BIT-1 down to 0; a bit advances on the cycle the timer is 0.
  - Bit counter is 6 bits wide; it wraps to 0 on each state change.
- Requests arriving while busy are only latched; they launch no earlier than the IDLE cycle after frame_done.
- Reset asserted mid-frame:
  - tx=1 and state IDLE on the next edge; the frame is truncated.
  - Pending flags and any latched keyboard payload are discarded.
  - No frame_done is emitted.

## Timing
- Pulse latency:
  - A pulse sampled at edge N sets its flag at N.
  - IDLE grants at edge N+1; tx=0 and busy=1 from edge N+1.
- Keyboard latency: handshake at edge N (kbd_valid && kbd_ready); tx=0 from edge N. kbd_ready drops from edge N because state≠IDLE.
- Frame length, start bit to the edge where IDLE is re-entered:
  - Without payload: (17+GUARD_BITS)×CLKS_PER_BIT cycles.
  - With payload: (49+GUARD_BITS)×CLKS_PER_BIT cycles.
- Back-to-back: with work pending at frame_done, the next start bit begins exactly 1 cycle after IDLE is re-entered (the IDLE grant cycle).

## Structure
- Shared package holds:
  - the opcode constants OP_PWR_REPLY, OP_KBD_EVENT, OP_AUDIO_REQ;
  - the state enum IDLE/START/OP/DATA/GUARD;
  - the frame widths OP_BITS=16 and KBD_BITS=32.
- The decoder side also imports this package.
- One sub-module: bit_timer (CLKS_PER_BIT down-counter with a load input and a tick output). Everything else stays in op_encoder_tx.

## Test plan
CLKS_PER_BIT=4 and GUARD_BITS=2 throughout.
- Single audio_req pulse, checked via tx:
  - start bit, then 0x0700 MSB-first, each bit 4 cycles;
  - 8 idle-high cycles, then frame_done;
  - total 76 cycles, tx low 2 cycles after the pulse.
- Keyboard event: kbd_valid with kbd_data=32'hA5C3_0F81 → handshake in the same cycle, then a 204-cycle frame carrying 0xD000 followed by 0xA5C30F81.
- Contention: power_on_reply, audio_req and kbd_valid all in one cycle:
  - frames go out in order 0xC5E0, 0xD000+payload, 0x0700;
  - kbd_ready stays 0 until the power frame has completed.
- Coalescing: three audio_req pulses during a keyboard frame → exactly one 0x0700 frame follows.
- Reset mid-payload (bit 20 of DATA): tx=1 next edge, busy=0, no frame_done, and no frame launches afterwards without new requests.
- Back-to-back: power_on_reply re-pulsed in the launch cycle → second 0xC5E0 start bit exactly 1 cycle after IDLE is re-entered.

Source files
------------

// File: rtl/op_encoder_tx_pkg.sv
// Shared opcode, state and frame-width definitions for the monitor-link opcode path.
// Imported by both the transmit encoder and the receive-side decoder.
package op_encoder_tx_pkg;

  localparam int OP_BITS    = 16;
  localparam int KBD_BITS   = 32;
  localparam int FRAME_BITS = OP_BITS + KBD_BITS;

  localparam logic [OP_BITS-1:0] OP_PWR_REPLY = 16'hC5E0;
  localparam logic [OP_BITS-1:0] OP_KBD_EVENT = 16'hD000;
  localparam logic [OP_BITS-1:0] OP_AUDIO_REQ = 16'h0700;

  typedef enum logic [2:0] {
    IDLE,
    START,
    OP,
    DATA,
    GUARD
  } state_t;

endpackage

// File: rtl/op_encoder_tx_bit_timer.sv
// Bit-period down-counter: ticks when it reaches 0, then reloads to CLKS_PER_BIT-1.
// Held at the reload value while load is high so a new frame starts on a full bit.
module bit_timer
  import op_encoder_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - 8'd1;
    if (load || cnt_q == 8'd0) cnt_d = RELOAD;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == 8'd0);

endmodule

// File: rtl/op_encoder_tx.sv
// Arbitrates power-on/keyboard/audio requests and shifts {opcode[,payload]} MSB-first on idle-high tx.
// Keyboard handshakes only in IDLE with no power reply pending; pulse sources coalesce into pending flags.
module op_encoder_tx
  import op_encoder_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int GUARD_BITS   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                power_on_reply,
  input  logic                audio_req,
  input  logic                kbd_valid,
  input  logic [KBD_BITS-1:0] kbd_data,
  output logic                kbd_ready,
  output logic                tx,
  output logic                busy,
  output logic                frame_done
);

  state_t                state_q, state_d;
  logic [5:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] sreg_q, sreg_d;
  logic                  has_data_q, has_data_d;
  logic                  pwr_pend_q, pwr_pend_d;
  logic                  aud_pend_q, aud_pend_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  bit_tick;
  logic                  launch_pwr, launch_kbd, launch_aud;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .load  (state_q == IDLE),
    .tick  (bit_tick)
  );

  assign kbd_ready  = (state_q == IDLE) && !pwr_pend_q;
  assign launch_pwr = (state_q == IDLE) && pwr_pend_q;
  assign launch_kbd = kbd_valid && kbd_ready;
  assign launch_aud = kbd_ready && !kbd_valid && aud_pend_q;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    sreg_d       = sreg_q;
    has_data_d   = has_data_q;
    frame_done_d = 1'b0;
    // A pulse coinciding with the launch of its own type re-arms the flag.
    pwr_pend_d   = power_on_reply | (pwr_pend_q & ~launch_pwr);
    aud_pend_d   = audio_req | (aud_pend_q & ~launch_aud);

    case (state_q)
      IDLE: begin
        if (launch_pwr || launch_kbd || launch_aud) begin
          state_d    = START;
          bit_cnt_d  = 6'd0;
          has_data_d = launch_kbd;
          if (launch_pwr)      sreg_d = {OP_PWR_REPLY, 32'h0};
          else if (launch_kbd) sreg_d = {OP_KBD_EVENT, kbd_data};
          else                 sreg_d = {OP_AUDIO_REQ, 32'h0};
        end
      end
      START: begin
        if (bit_tick) begin
          state_d   = OP;
          bit_cnt_d = 6'd0;
        end
      end
      OP: begin
        if (bit_tick) begin
          sreg_d    = sreg_q << 1;
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'(OP_BITS - 1)) begin
            state_d   = has_data_q ? DATA : GUARD;
            bit_cnt_d = 6'd0;
          end
        end
      end
      DATA: begin
        if (bit_tick) begin
          sreg_d    = sreg_q << 1;
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'(KBD_BITS - 1)) begin
            state_d   = GUARD;
            bit_cnt_d = 6'd0;
          end
        end
      end
      GUARD: begin
        if (bit_tick) begin
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'(GUARD_BITS - 1)) begin
            state_d      = IDLE;
            bit_cnt_d    = 6'd0;
            frame_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line value follows the next state so tx stays a pure flop output.
    busy_d = (state_d != IDLE);
    tx_d   = 1'b1;
    if (state_d == START)                     tx_d = 1'b0;
    else if (state_d == OP || state_d == DATA) tx_d = sreg_d[FRAME_BITS-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 6'd0;
      sreg_q       <= '0;
      has_data_q   <= 1'b0;
      pwr_pend_q   <= 1'b0;
      aud_pend_q   <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      sreg_q       <= sreg_d;
      has_data_q   <= has_data_d;
      pwr_pend_q   <= pwr_pend_d;
      aud_pend_q   <= aud_pend_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_op_encoder_tx.sv
// Bench for op_encoder_tx: directed scenarios plus random traffic against a frame-level model,
// with a serial receiver decoding tx into frames.
module tb_op_encoder_tx;

  localparam int C = 4;
  localparam int G = 2;
  localparam logic [15:0] OP_PWR = 16'hC5E0;
  localparam logic [15:0] OP_KBD = 16'hD000;
  localparam logic [15:0] OP_AUD = 16'h0700;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        power_on_reply = 1'b0;
  logic        audio_req = 1'b0;
  logic        kbd_valid = 1'b0;
  logic [31:0] kbd_data = 32'h0;
  logic        kbd_ready, tx, busy, frame_done;

  op_encoder_tx #(.CLKS_PER_BIT(C), .GUARD_BITS(G)) dut (
    .clk            (clk),
    .reset          (reset),
    .power_on_reply (power_on_reply),
    .audio_req      (audio_req),
    .kbd_valid      (kbd_valid),
    .kbd_data       (kbd_data),
    .kbd_ready      (kbd_ready),
    .tx             (tx),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit chk_en   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Frame-level model: a launched frame is a list of bits, each held C cycles.
  bit          m_busy, m_pwr, m_aud, m_has, m_done;
  int          m_off, m_len;
  logic [15:0] m_op;
  logic [31:0] m_pay;

  task automatic model_step();
    bit lp, lk, la;
    lp = 0; lk = 0; la = 0; m_done = 0;
    if (reset) begin
      m_busy = 0; m_pwr = 0; m_aud = 0; m_off = 0;
      return;
    end
    if (m_busy) begin
      m_off++;
      if (m_off == m_len) begin m_busy = 0; m_done = 1; end
    end else if (m_pwr) lp = 1;
    else if (kbd_valid) lk = 1;
    else if (m_aud) la = 1;
    if (lp || lk || la) begin
      m_busy = 1; m_off = 0; m_has = lk;
      m_op   = lp ? OP_PWR : (lk ? OP_KBD : OP_AUD);
      m_pay  = lk ? kbd_data : 32'h0;
      m_len  = ((lk ? 49 : 17) + G) * C;
    end
    m_pwr = power_on_reply || (m_pwr && !lp);
    m_aud = audio_req || (m_aud && !la);
  endtask

  function automatic logic exp_tx();
    int b;
    if (!m_busy) return 1'b1;
    b = m_off / C;
    if (b == 0) return 1'b0;
    if (b <= 16) return m_op[16-b];
    if (m_has && b <= 48) return m_pay[48-b];
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Serial receiver: mid-bit sampling of tx, 16 opcode bits plus 32 more after a keyboard opcode.
  logic [47:0] rx_q[$];
  logic [47:0] rx_sh;
  bit          rx_act, rx_arm;
  int          rx_t, rx_n;

  function automatic logic [47:0] rxq_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 48'hFFFF_FFFF_FFFF;
  endfunction

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check_eq("tx", 64'(tx), 64'(exp_tx()));
      check_eq("busy", 64'(busy), 64'(m_busy));
      check_eq("frame_done", 64'(frame_done), 64'(m_done));
      check_eq("kbd_ready", 64'(kbd_ready), 64'(!m_busy && !m_pwr));
    end
    if (reset) begin
      rx_act = 0; rx_arm = 0;
    end else if (!rx_act) begin
      if (tx) rx_arm = 1;
      else if (rx_arm) begin rx_act = 1; rx_t = 0; rx_n = 0; rx_sh = '0; end
    end else begin
      rx_t++;
      if (rx_t >= C && (rx_t % C) == C / 2) begin
        rx_sh = {rx_sh[46:0], tx};
        rx_n++;
        if ((rx_n == 16 && rx_sh[15:0] != OP_KBD) || rx_n == 48) begin
          rx_q.push_back(rx_n == 16 ? {rx_sh[15:0], 32'h0} : rx_sh);
          rx_act = 0; rx_arm = 0;
        end
      end
    end
  end

  // which: 0 = tx low, 1 = frame_done, 2 = kbd_ready, 3 = four frames received
  task automatic wait_for(input int which, input int max, output int t);
    bit hit;
    hit = 0;
    for (int i = 0; i < max && !hit; i++) begin
      tick();
      if ((which == 0 && tx == 1'b0) || (which == 1 && frame_done == 1'b1) ||
          (which == 2 && kbd_ready == 1'b1) || (which == 3 && rx_q.size() >= 4)) hit = 1;
    end
    t = cyc;
    check_eq($sformatf("wait_%0d", which), 64'(hit), 64'd1);
  endtask

  initial begin
    int t0, t1, t2;
    bit busy_seen, done_seen, hs;
    logic [31:0] kd;

    idle(3);
    reset = 1'b0;
    chk_en = 1;
    check_eq("rst_tx", 64'(tx), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_frame_done", 64'(frame_done), 64'd0);
    check_eq("rst_kbd_ready", 64'(kbd_ready), 64'd1);

    // Single audio request
    rx_q.delete();
    t0 = cyc; audio_req = 1; tick(); audio_req = 0;
    wait_for(0, 10, t1);
    check_eq("aud_start_lat", 64'(t1 - t0), 64'd2);
    wait_for(1, 200, t2);
    check_eq("aud_frame_len", 64'(t2 - t1), 64'd76);
    idle(4);
    check_eq("aud_count", 64'(rx_q.size()), 64'd1);
    check_eq("aud_frame", 64'(rxq_at(0)), {16'h0, OP_AUD, 32'h0});

    // Keyboard event: handshake and start bit on the same edge
    rx_q.delete();
    check_eq("kbd_ready_idle", 64'(kbd_ready), 64'd1);
    kbd_valid = 1; kbd_data = 32'hA5C3_0F81; tick(); kbd_valid = 0; t1 = cyc;
    check_eq("kbd_tx_low", 64'(tx), 64'd0);
    check_eq("kbd_ready_drop", 64'(kbd_ready), 64'd0);
    wait_for(1, 300, t2);
    check_eq("kbd_frame_len", 64'(t2 - t1), 64'd204);
    idle(4);
    check_eq("kbd_count", 64'(rx_q.size()), 64'd1);
    check_eq("kbd_frame", 64'(rxq_at(0)), {16'h0, OP_KBD, 32'hA5C3_0F81});

    // Contention: all three sources raised in one cycle while an audio frame is on the line
    rx_q.delete();
    audio_req = 1; tick(); audio_req = 0;
    wait_for(0, 10, t1);
    idle(5);
    power_on_reply = 1; audio_req = 1; kbd_valid = 1; kbd_data = 32'h1234_5678;
    tick(); power_on_reply = 0; audio_req = 0;
    wait_for(2, 400, t2);
    check_eq("cont_rdy_at_pwr_done", 64'(frame_done), 64'd1);
    check_eq("cont_frames_before_kbd", 64'(rx_q.size()), 64'd2);
    check_eq("cont_pwr_first", 64'(rxq_at(1)), {16'h0, OP_PWR, 32'h0});
    tick(); kbd_valid = 0;
    wait_for(3, 600, t2);
    idle(40);
    check_eq("cont_count", 64'(rx_q.size()), 64'd4);
    check_eq("cont_kbd", 64'(rxq_at(2)), {16'h0, OP_KBD, 32'h1234_5678});
    check_eq("cont_aud_last", 64'(rxq_at(3)), {16'h0, OP_AUD, 32'h0});

    // Coalescing: three audio pulses during a keyboard frame yield one audio frame
    rx_q.delete();
    kd = $urandom;
    kbd_valid = 1; kbd_data = kd; tick(); kbd_valid = 0;
    for (int i = 0; i < 3; i++) begin idle(30); audio_req = 1; tick(); audio_req = 0; end
    wait_for(1, 300, t2);
    wait_for(1, 200, t2);
    idle(150);
    check_eq("coal_count", 64'(rx_q.size()), 64'd2);
    check_eq("coal_kbd", 64'(rxq_at(0)), {16'h0, OP_KBD, kd});
    check_eq("coal_aud", 64'(rxq_at(1)), {16'h0, OP_AUD, 32'h0});

    // Reset during payload bit 20, with an audio request pending
    rx_q.delete();
    kbd_valid = 1; kbd_data = $urandom; tick(); kbd_valid = 0; t1 = cyc;
    idle(100); audio_req = 1; tick(); audio_req = 0;
    while (cyc < t1 + 149) tick();
    check_eq("mid_busy", 64'(busy), 64'd1);
    reset = 1; tick(); reset = 0;
    check_eq("mid_rst_tx", 64'(tx), 64'd1);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_done", 64'(frame_done), 64'd0);
    busy_seen = 0; done_seen = 0;
    repeat (300) begin tick(); busy_seen |= busy; done_seen |= frame_done; end
    check_eq("mid_no_relaunch", 64'(busy_seen), 64'd0);
    check_eq("mid_no_done", 64'(done_seen), 64'd0);
    check_eq("mid_no_frames", 64'(rx_q.size()), 64'd0);

    // Back-to-back: power reply re-pulsed on its own launch edge
    rx_q.delete();
    power_on_reply = 1; tick(); tick(); power_on_reply = 0; t1 = cyc;
    check_eq("b2b_launch", 64'(tx), 64'd0);
    wait_for(1, 200, t2);
    check_eq("b2b_len", 64'(t2 - t1), 64'd76);
    wait_for(0, 10, t0);
    check_eq("b2b_gap", 64'(t0 - t2), 64'd1);
    wait_for(1, 200, t2);
    idle(100);
    check_eq("b2b_count", 64'(rx_q.size()), 64'd2);
    check_eq("b2b_second", 64'(rxq_at(1)), {16'h0, OP_PWR, 32'h0});

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      power_on_reply = ($urandom_range(0, 63) == 0);
      audio_req      = ($urandom_range(0, 47) == 0);
      reset          = ($urandom_range(0, 1499) == 0);
      hs = kbd_valid && kbd_ready && !reset;
      tick();
      if (hs) kbd_valid = 0;
      else if (!kbd_valid && $urandom_range(0, 39) == 0) begin
        kbd_valid = 1; kbd_data = $urandom;
      end
    end
    power_on_reply = 0; audio_req = 0; reset = 0; kbd_valid = 0;
    idle(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
